// File: rtl/pipe_skid_pr.sv
// Elastic pipeline register with a 2-entry skid buffer, registered upstream ready,
// legacy stall/flush controls and a saturating backpressure counter.
module pipe_skid_pr #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned CTRL_W         = 7,
    parameter int unsigned IDX_W          = 3,
    parameter int unsigned CNT_W          = 16,
    parameter bit          CLEAR_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [IDX_W-1:0]  dst_idx_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [IDX_W-1:0]  dst_idx_out,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bp_cycles
);

    typedef enum logic [1:0] {StEmpty = 2'd0, StOne = 2'd1, StFull = 2'd2} state_e;

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [IDX_W-1:0]  main_idx_q, main_idx_d, skid_idx_q, skid_idx_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  bp_q, bp_d;
    logic              acc, dep, out_blocked;

    assign valid_out   = (state_q != StEmpty);
    assign ready_out   = ready_q;
    assign ctrl_out    = main_ctrl_q;
    assign dst_idx_out = main_idx_q;
    assign data_out    = main_data_q;
    assign occupancy   = {state_q == StFull, state_q == StOne};
    assign bp_cycles   = bp_q;

    assign acc         = valid_in & ready_q;
    assign out_blocked = ~(ready_in & ~stall);
    assign dep         = valid_out & ~out_blocked;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_idx_d  = main_idx_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_idx_d  = skid_idx_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            state_d = StEmpty;
            if (CLEAR_ON_FLUSH) begin
                main_ctrl_d = '0;
                main_idx_d  = '0;
                main_data_d = '0;
                skid_ctrl_d = '0;
                skid_idx_d  = '0;
                skid_data_d = '0;
            end
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (acc) begin
                        state_d     = StOne;
                        main_ctrl_d = ctrl_in;
                        main_idx_d  = dst_idx_in;
                        main_data_d = data_in;
                    end
                end
                StOne: begin
                    if (acc && dep) begin
                        main_ctrl_d = ctrl_in;
                        main_idx_d  = dst_idx_in;
                        main_data_d = data_in;
                    end else if (acc) begin
                        state_d     = StFull;
                        skid_ctrl_d = ctrl_in;
                        skid_idx_d  = dst_idx_in;
                        skid_data_d = data_in;
                    end else if (dep) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    // ready_out is low here, so only the skid-to-main move can happen
                    if (dep) begin
                        state_d     = StOne;
                        main_ctrl_d = skid_ctrl_q;
                        main_idx_d  = skid_idx_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end

        ready_d = (state_d != StFull);

        bp_d = bp_q;
        if (valid_out && out_blocked && (bp_q != {CNT_W{1'b1}})) begin
            bp_d = bp_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StEmpty;
            ready_q     <= 1'b1;
            main_ctrl_q <= '0;
            main_idx_q  <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_idx_q  <= '0;
            skid_data_q <= '0;
            bp_q        <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            main_ctrl_q <= main_ctrl_d;
            main_idx_q  <= main_idx_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_idx_q  <= skid_idx_d;
            skid_data_q <= skid_data_d;
            bp_q        <= bp_d;
        end
    end

endmodule
